// File: rtl/alu_nibble_sequencer.sv
// Nibble-serial front end for a 74181-style 4-bit ALU slice: one WIDTH-bit op, one nibble per clock, LSB first.
// Latency: result valid NIB cycles after the accept edge; next accept no sooner than NIB+2 cycles after.
// Backpressure: result is held in DONE until out_ready; in_ready is low (and in_valid ignored) outside IDLE.

// One 74181 slice with active-high data. t1/t2 are the two internal operand terms
// selected by S; arithmetic adds them with carry, logic mode XNORs them carry-free.
module alu (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic [3:0] i_s,
  input  logic       i_m,
  input  logic       i_cn,
  output logic [3:0] o_f,
  output logic       o_cn_4,
  output logic       o_a_eq_b
);

  logic [3:0] w_t1;
  logic [3:0] w_t2;
  logic [4:0] w_sum;

  assign w_t1  = i_a | (i_b & {4{i_s[0]}}) | (~i_b & {4{i_s[1]}});
  assign w_t2  = (i_a & i_b & {4{i_s[3]}}) | (i_a & ~i_b & {4{i_s[2]}});
  // Carry pins are active-low: cn=0 injects a carry, cn_4=0 reports one.
  assign w_sum = {1'b0, w_t1} + {1'b0, w_t2} + {4'b0000, ~i_cn};

  // The carry lookahead does not depend on M, so cn_4 stays live in logic mode.
  assign o_f      = i_m ? ~(w_t1 ^ w_t2) : w_sum[3:0];
  assign o_cn_4   = ~w_sum[4];
  assign o_a_eq_b = &o_f;

endmodule

module alu_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_s,
  input  logic             in_m,
  input  logic             in_cn,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_f,
  output logic             out_cout,
  output logic             out_eq
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;

  logic [3:0]       r_s;
  logic             r_m;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry;
  logic             r_eq;
  logic [WIDTH-1:0] r_f;

  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [3:0]       w_alu_f;
  logic             w_alu_cn4;
  logic             w_alu_aeqb;

  // The slice sees only registered state, so its inputs are glitch-free and one nibble per cycle.
  assign w_a_nib = r_a[{r_idx, 2'b00} +: 4];
  assign w_b_nib = r_b[{r_idx, 2'b00} +: 4];

  alu u_alu (
    .i_a      (w_a_nib),
    .i_b      (w_b_nib),
    .i_s      (r_s),
    .i_m      (r_m),
    .i_cn     (r_carry),
    .o_f      (w_alu_f),
    .o_cn_4   (w_alu_cn4),
    .o_a_eq_b (w_alu_aeqb)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (r_idx == LAST_IDX) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand capture on accept, then one nibble of result, carry and equality per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s     <= 4'h0;
      r_m     <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_carry <= 1'b1;
      r_eq    <= 1'b0;
      r_f     <= '0;
    end else if (w_accept) begin
      r_s     <= in_s;
      r_m     <= in_m;
      r_a     <= in_a;
      r_b     <= in_b;
      r_idx   <= '0;
      r_carry <= in_cn;
      r_eq    <= 1'b1;
      r_f     <= '0;
    end else if (r_state == S_RUN) begin
      r_f[{r_idx, 2'b00} +: 4] <= w_alu_f;
      r_carry                  <= w_alu_cn4;
      r_eq                     <= r_eq & w_alu_aeqb;
      // idx parks on the last nibble rather than wrapping; accept clears it.
      if (r_idx != LAST_IDX) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign out_f    = r_f;
  assign out_cout = r_carry;
  assign out_eq   = r_eq;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer at WIDTH=16: directed ops with literal results plus a full S/M sweep.
// Results are checked every valid cycle against a whole-word 74181 function-table model.
// Backpressure, ignored in_valid, operand changes after accept and mid-op reset are exercised.
module tb_alu_nibble_sequencer;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_s;
  logic             in_m;
  logic             in_cn;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_f;
  logic             out_cout;
  logic             out_eq;

  int n_checks = 0;
  int n_pass   = 0;
  logic [17:0] exp_q[$];

  alu_nibble_sequencer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_s      (in_s),
    .in_m      (in_m),
    .in_cn     (in_cn),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_f     (out_f),
    .out_cout  (out_cout),
    .out_eq    (out_eq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Whole-word 74181 behaviour. Arithmetic functions are written in datasheet form
  // "P plus Q" (minus 1 is plus all-ones); cout is the active-low carry of that sum,
  // which the chip reports in logic mode too. eq is the open-collector AND of F.
  function automatic logic [17:0] model(input logic [3:0] s, input logic m, input logic cn,
                                        input logic [15:0] a, input logic [15:0] b);
    logic [15:0] p, q, lf, f;
    logic [16:0] sum;
    case (s)
      4'd0:  begin p = a;        q = 16'h0000; lf = ~a;       end
      4'd1:  begin p = a | b;    q = 16'h0000; lf = ~(a | b); end
      4'd2:  begin p = a | ~b;   q = 16'h0000; lf = ~a & b;   end
      4'd3:  begin p = 16'hFFFF; q = 16'h0000; lf = 16'h0000; end
      4'd4:  begin p = a;        q = a & ~b;   lf = ~(a & b); end
      4'd5:  begin p = a | b;    q = a & ~b;   lf = ~b;       end
      4'd6:  begin p = a;        q = ~b;       lf = a ^ b;    end
      4'd7:  begin p = a & ~b;   q = 16'hFFFF; lf = a & ~b;   end
      4'd8:  begin p = a;        q = a & b;    lf = ~a | b;   end
      4'd9:  begin p = a;        q = b;        lf = ~(a ^ b); end
      4'd10: begin p = a | ~b;   q = a & b;    lf = b;        end
      4'd11: begin p = a & b;    q = 16'hFFFF; lf = a & b;    end
      4'd12: begin p = a;        q = a;        lf = 16'hFFFF; end
      4'd13: begin p = a | b;    q = a;        lf = a | ~b;   end
      4'd14: begin p = a | ~b;   q = a;        lf = a | b;    end
      default: begin p = a;      q = 16'hFFFF; lf = a;        end
    endcase
    sum = {1'b0, p} + {1'b0, q} + {16'h0000, ~cn};
    f = m ? lf : sum[15:0];
    return {f, ~sum[16], &f};
  endfunction

  // Result checker: every cycle out_valid is high the outputs must equal the oldest expected op.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        check("result_f_cout_eq", {14'd0, out_f, out_cout, out_eq}, {14'd0, exp_q[0]});
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Called just after a rising edge. Runs one op, optionally stalling the result and
  // toggling in_valid with junk while busy, and returns the DUT's {f,cout,eq}.
  task automatic do_op(input logic [3:0] s, input logic m, input logic cn,
                       input logic [15:0] a, input logic [15:0] b,
                       input int stall, input bit noisy, output logic [17:0] res);
    int lat;
    lat = 0;
    while (!in_ready && lat < 20) begin @(posedge clk); #1; lat++; end
    check("in_ready_before_op", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_s = s; in_m = m; in_cn = cn; in_a = a; in_b = b;
    @(posedge clk);
    exp_q.push_back(model(s, m, cn, a, b));
    #1;
    in_valid = noisy;
    in_s = ~s; in_m = ~m; in_cn = ~cn; in_a = ~a; in_b = a ^ b ^ 16'h5A5A;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("accept_to_valid_latency", lat, NIB);
    res = {out_f, out_cout, out_eq};
    for (int i = 0; i < stall; i++) begin
      check("in_ready_low_in_done", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("handshake_returns_idle", {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  logic [17:0] r;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_s = 4'h0; in_m = 1'b0; in_cn = 1'b1;
    in_a = '0; in_b = '0; out_ready = 1'b0;
    #12;
    check("reset_outputs", {12'd0, out_valid, in_ready, out_f, out_cout, out_eq},
          {12'd0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0});
    @(posedge clk); #1;
    rst = 1'b0;

    // Add, no carry in, then overflow.
    do_op(4'b1001, 1'b0, 1'b1, 16'h1234, 16'h4321, 0, 1'b0, r);
    check("add_1234_4321", r[17:1], {16'h5555, 1'b1});
    do_op(4'b1001, 1'b0, 1'b1, 16'hFFFF, 16'h0001, 0, 1'b0, r);
    check("add_ffff_0001", r[17:1], {16'h0000, 1'b0});
    // XOR in logic mode.
    do_op(4'b0110, 1'b1, 1'b1, 16'hF0F0, 16'hFF00, 0, 1'b0, r);
    check("xor_f0f0_ff00", {r[17:2], r[0]}, {16'h0FF0, 1'b0});
    // Compare via A minus B minus 1.
    do_op(4'b0110, 1'b0, 1'b1, 16'hABCD, 16'hABCD, 0, 1'b0, r);
    check("cmp_equal", {r[17:2], r[0]}, {16'hFFFF, 1'b1});
    do_op(4'b0110, 1'b0, 1'b1, 16'hABCD, 16'hABCC, 0, 1'b0, r);
    check("cmp_unequal", {r[17:2], r[0]}, {16'h0000, 1'b0});

    // Backpressure for 5 cycles with in_valid asserted throughout the op.
    do_op(4'b1001, 1'b0, 1'b0, 16'h00FF, 16'h0F00, 5, 1'b1, r);
    check("add_carry_in_stalled", r, {16'h1000, 1'b1, 1'b0});
    for (int i = 0; i < NIB + 2; i++) begin
      check("no_queued_op", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
    end

    // Reset while the third nibble is in flight.
    in_valid = 1'b1; in_s = 4'b1001; in_m = 1'b0; in_cn = 1'b1; in_a = 16'h7777; in_b = 16'h1111;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("reset_mid_run", {12'd0, out_valid, in_ready, out_f, out_cout, out_eq},
          {12'd0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0});
    #1;
    rst = 1'b0;
    do_op(4'b1001, 1'b0, 1'b1, 16'h0F0F, 16'h0101, 0, 1'b0, r);
    check("add_after_reset", r[17:1], {16'h1010, 1'b1});

    // Every S/M combination against the model with random operands, carry and stalls.
    for (int sm = 0; sm < 32; sm++) begin
      for (int k = 0; k < 200; k++) begin
        do_op(sm[3:0], sm[4], 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
              int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), r);
      end
    end

    check("all_results_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
